// File: rtl/sp_sync_ram.sv
// sp_sync_ram: single-port synchronous RAM with registered read data and a
// read-valid strobe. The array has no reset so it maps onto block RAM; only
// the output registers are cleared by rst_n.
//
// Optional build macro: SP_SYNC_RAM_OUT_REG_EN
//   undefined : read latency 1 cycle
//   defined   : extra output pipeline stage, read latency 2 cycles
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (output registers only)
//   addr     word address for read or write
//   data_in  write data
//   data_out registered read data; holds when no read completes
//   cs       chip select; no operation when low
//   we       write enable, qualified by cs (1 = write, 0 = read)
//   valid    one-cycle strobe per completed read
module sp_sync_ram #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  cs,
  input  logic                  we,
  output logic                  valid
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  do_write_c;
  logic                  do_read_c;

  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  // Request decode; addresses at or beyond DEPTH never touch the array.
  always_comb begin
    in_range_c = ({1'b0, addr} < DEPTH_LIM);
    idx_c      = addr[IDX_W-1:0];
    do_write_c = cs && we;
    do_read_c  = cs && !we;
  end

  // Array write port; requests during reset are ignored.
  always_ff @(posedge clk) begin
    if (rst_n && do_write_c && in_range_c) begin
      mem[idx_c] <= data_in;
    end
  end

  // First read stage: out-of-range reads return zero but still complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_read_c;
      if (do_read_c) begin
        rd_data <= in_range_c ? mem[idx_c] : '0;
      end
    end
  end

`ifdef SP_SYNC_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;

  // Second stage: bubbles pass through, data holds until the next read lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_valid;
      if (rd_valid) begin
        out_data <= rd_data;
      end
    end
  end

  assign data_out = out_data;
  assign valid    = out_valid;
`else
  assign data_out = rd_data;
  assign valid    = rd_valid;
`endif

endmodule

// File: tb/tb_sp_sync_ram.sv
// Self-checking bench for sp_sync_ram: directed test-plan sequence with
// literal expectations, followed by randomized traffic. A behavioural model
// (shadow memory plus a latency delay line) is checked every cycle.
module tb_sp_sync_ram;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4096;
`ifdef SP_SYNC_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          cs;
  logic          we;
  logic          valid;

  sp_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .cs       (cs),
    .we       (we),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic [DW-1:0] shadow  [DEPTH];
  bit            written [DEPTH];
  bit            pv [LAT];
  logic [DW-1:0] pd [LAT];
  bit            pk [LAT];
  bit            exp_valid = 1'b0;
  logic [DW-1:0] exp_data  = '0;
  bit            exp_known = 1'b1;
  bit            live      = 1'b0;

  // Model: each edge produces one request result that emerges LAT edges
  // later; data_out keeps the last read that emerged, reset clears everything.
  always @(posedge clk) begin
    bit            nv;
    logic [DW-1:0] nd;
    bit            nk;
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] = 1'b0; pd[i] = '0; pk[i] = 1'b1;
      end
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_known = 1'b1;
    end else begin
      nv = cs && !we;
      nd = '0;
      nk = 1'b1;
      if (nv && (int'(addr) < DEPTH)) begin
        nk = written[addr];
        nd = shadow[addr];
      end
      if (cs && we && (int'(addr) < DEPTH)) begin
        shadow[addr]  = data_in;
        written[addr] = 1'b1;
      end
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1]; pd[i] = pd[i-1]; pk[i] = pk[i-1];
      end
      pv[0] = nv; pd[0] = nd; pk[0] = nk;
      exp_valid = pv[LAT-1];
      if (pv[LAT-1]) begin
        exp_data  = pd[LAT-1];
        exp_known = pk[LAT-1];
      end
    end
    live = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      vectors++;
      if (valid !== exp_valid) begin
        miscompares++;
        $display("FAIL model_valid t=%0t got=%b want=%b", $time, valid, exp_valid);
      end
      if (exp_known && (data_out !== exp_data)) begin
        miscompares++;
        $display("FAIL model_data t=%0t got=%h want=%h", $time, data_out, exp_data);
      end
    end
  end

  // Output log indexed by request cycle: result of request n is at n+LAT-1.
  bit            log_v [8192];
  logic [DW-1:0] log_d [8192];
  int            ncyc = 0;

  task automatic cyc(input logic c, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output int idx);
    cs = c; we = w; addr = a; data_in = d;
    @(negedge clk);
    idx = ncyc;
    log_v[ncyc] = valid;
    log_d[ncyc] = data_out;
    ncyc++;
  endtask

  task automatic lit(input string name, input logic [DW-1:0] got,
                     input logic [DW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    int dummy;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, AW'(257), '0, dummy);
  endtask

  initial begin
    int i_rst, i_r5, i_r256, i_r1, i_r10, i_r63, i_des;
    int i_ra, i_w10, i_rb, i_r0, i_r4095, i_mr;
    int t;
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    @(negedge clk);

    // Reset with a write request present: outputs clear, write dropped.
    cyc(1'b1, 1'b1, AW'(5), 64'h1111, t);
    cyc(1'b1, 1'b1, AW'(5), 64'h1111, i_rst);
    lit("reset_valid", 64'(log_v[i_rst]), 64'h0);
    lit("reset_data", log_d[i_rst], 64'h0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, AW'(5), '0, i_r5);
    idle(LAT);
    lit("reset_rd5_valid", 64'(log_v[i_r5+LAT-1]), 64'h1);
    vectors++;
    if (log_d[i_r5+LAT-1] === 64'h1111) begin
      miscompares++;
      $display("FAIL reset_no_write got=%h want=not_1111", log_d[i_r5+LAT-1]);
    end

    // Write then read.
    cyc(1'b1, 1'b1, AW'(256), 64'h00000000ABCDE123, t);
    cyc(1'b1, 1'b0, AW'(256), '0, i_r256);
    idle(LAT);
    lit("wr_rd_valid", 64'(log_v[i_r256+LAT-1]), 64'h1);
    lit("wr_rd_data", log_d[i_r256+LAT-1], 64'h00000000ABCDE123);

    // Streaming reads, then deselect.
    cyc(1'b1, 1'b1, AW'(1), 64'h11, t);
    cyc(1'b1, 1'b1, AW'(10), 64'hAA, t);
    cyc(1'b1, 1'b1, AW'(63), 64'h3F, t);
    cyc(1'b1, 1'b0, AW'(1), '0, i_r1);
    cyc(1'b1, 1'b0, AW'(10), '0, i_r10);
    cyc(1'b1, 1'b0, AW'(63), '0, i_r63);
    cyc(1'b0, 1'b1, AW'(257), '0, i_des);
    idle(LAT);
    lit("stream0", log_d[i_r1+LAT-1], 64'h11);
    lit("stream1", log_d[i_r10+LAT-1], 64'hAA);
    lit("stream2", log_d[i_r63+LAT-1], 64'h3F);
    lit("stream_valid", {61'h0, log_v[i_r1+LAT-1], log_v[i_r10+LAT-1], log_v[i_r63+LAT-1]}, 64'h7);
    lit("desel_valid", 64'(log_v[i_des+LAT-1]), 64'h0);
    lit("desel_hold", log_d[i_des+LAT-1], 64'h3F);

    // Write does not disturb the output register.
    cyc(1'b1, 1'b0, AW'(10), '0, i_ra);
    cyc(1'b1, 1'b1, AW'(10), 64'h55, i_w10);
    cyc(1'b1, 1'b0, AW'(10), '0, i_rb);
    idle(LAT);
    lit("wr_quiet_rd", log_d[i_ra+LAT-1], 64'hAA);
    lit("wr_quiet_valid", 64'(log_v[i_w10+LAT-1]), 64'h0);
    lit("wr_quiet_hold", log_d[i_w10+LAT-1], 64'hAA);
    lit("wr_quiet_new", log_d[i_rb+LAT-1], 64'h55);

    // Boundary addresses.
    cyc(1'b1, 1'b1, AW'(0), 64'hDEAD, t);
    cyc(1'b1, 1'b1, AW'(4095), 64'hBEEF, t);
    cyc(1'b1, 1'b0, AW'(0), '0, i_r0);
    cyc(1'b1, 1'b0, AW'(4095), '0, i_r4095);
    idle(LAT);
    lit("bound_lo", log_d[i_r0+LAT-1], 64'hDEAD);
    lit("bound_hi", log_d[i_r4095+LAT-1], 64'hBEEF);

    // Reset mid-stream cancels reads in flight.
    cyc(1'b1, 1'b0, AW'(1), '0, t);
    cyc(1'b1, 1'b0, AW'(10), '0, t);
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, AW'(63), '0, i_mr);
    rst_n = 1'b1;
    lit("midrst_valid", 64'(log_v[i_mr]), 64'h0);
    lit("midrst_data", log_d[i_mr], 64'h0);
    idle(LAT);

    // Randomized traffic over a small hot set plus the address extremes.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] a;
      logic c, w;
      case ($urandom_range(0, 9))
        0:       a = AW'(0);
        1:       a = AW'(4095);
        2:       a = AW'($urandom_range(0, 4095));
        default: a = AW'($urandom_range(0, 31));
      endcase
      c = ($urandom_range(0, 9) < 8);
      w = ($urandom_range(0, 9) < 4);
      rst_n = ($urandom_range(0, 99) != 0);
      cs = c; we = w; addr = a; data_in = {$urandom, $urandom};
      @(negedge clk);
    end
    rst_n = 1'b1;
    cs = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
